// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant, IDLE/SETUP/ACCESS sequencing,
// wait-state handling with optional timeout, and registered response return.
module apb_master_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [7:0]  pwdata,
  input  logic [7:0]  prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state, state_nxt;
  logic            last;
  logic            gnt;
  logic [CW-1:0]   cnt;
  logic            any_req;
  logic            pick;
  logic            done_ok;
  logic            tmo;

  always_comb begin
    any_req   = |req_valid;
    pick      = (req_valid == 2'b11) ? ~last : req_valid[1];
    done_ok   = (state == ACCESS) && pready;
    tmo       = (state == ACCESS) && !pready && (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done_ok || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= 1'b0;
      cnt       <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= '0;
      rsp_valid <= '0;
      // Bus strobes are registered from the next state so they track SETUP/ACCESS exactly.
      psel      <= (state_nxt != IDLE);
      penable   <= (state_nxt == ACCESS);

      if (state == ACCESS && !pready) cnt <= cnt + 1'b1;
      else if (state != ACCESS)       cnt <= '0;

      if (state == IDLE && any_req) begin
        req_ready <= pick ? 2'b10 : 2'b01;
        gnt       <= pick;
        last      <= pick;
        pwrite    <= req_write[pick];
        paddr     <= pick ? req_addr[63:32] : req_addr[31:0];
        pwdata    <= pick ? req_wdata[15:8] : req_wdata[7:0];
      end

      if (done_ok || tmo) begin
        rsp_valid <= gnt ? 2'b10 : 2'b01;
        rsp_err   <= tmo ? 1'b1 : pslverr;
        rsp_rdata <= (tmo || pwrite) ? 8'h00 : prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb; inputs driven and outputs sampled on the falling edge.
module tb_apb_master_arb;

  logic        pclk = 1'b0;
  logic        prst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;

  int pass_cnt = 0;
  int total    = 0;

  apb_master_arb #(.TIMEOUT(4)) dut (
    .pclk      (pclk),
    .prst      (prst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic test_reset();
    prst = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) tick();
    total++;
    if ({psel, penable, pwrite, rsp_err} !== 4'b0000)
      $display("FAIL rst_ctrl: got %b want 0000", {psel, penable, pwrite, rsp_err});
    else pass_cnt++;
    total++;
    if ({req_ready, rsp_valid} !== 4'b0000)
      $display("FAIL rst_pulses: got %b want 0000", {req_ready, rsp_valid});
    else pass_cnt++;
    total++;
    if ({paddr, pwdata, rsp_rdata} !== 48'h0)
      $display("FAIL rst_data: got %h want 0", {paddr, pwdata, rsp_rdata});
    else pass_cnt++;
    prst = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h10; req_wdata[7:0] = 8'hA5;
    pready = 1'b1;
    tick();
    total++;
    if ({req_ready, psel, penable} !== 4'b0110)
      $display("FAIL wr_grant_setup: got %b want 0110", {req_ready, psel, penable});
    else pass_cnt++;
    req_valid = '0;
    tick();
    total++;
    if ({req_ready, psel, penable, pwrite, paddr, pwdata} !== {2'b00, 3'b111, 32'h10, 8'hA5})
      $display("FAIL wr_access: got %b %b %b %b %h %h want 00 1 1 1 00000010 a5",
               req_ready, psel, penable, pwrite, paddr, pwdata);
    else pass_cnt++;
    tick();
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, penable} !== {2'b01, 1'b0, 8'h00, 2'b00})
      $display("FAIL wr_rsp: got v=%b e=%b d=%h sel=%b en=%b want v=01 e=0 d=00 sel=0 en=0",
               rsp_valid, rsp_err, rsp_rdata, psel, penable);
    else pass_cnt++;
    tick();
    total++;
    if (rsp_valid !== 2'b00) $display("FAIL wr_rsp_pulse: got %b want 00", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_read_wait();
    req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h4; pready = 1'b0;
    tick();
    total++;
    if (req_ready !== 2'b10) $display("FAIL rd_grant: got %b want 10", req_ready);
    else pass_cnt++;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({psel, penable, rsp_valid} !== 4'b1100)
        $display("FAIL rd_access_%0d: got %b want 1100", i, {psel, penable, rsp_valid});
      else pass_cnt++;
      if (i == 3) begin
        pready = 1'b1; prdata = 8'h3C;
      end
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel} !== {2'b10, 1'b0, 8'h3C, 1'b0})
      $display("FAIL rd_rsp: got v=%b e=%b d=%h sel=%b want v=10 e=0 d=3c sel=0",
               rsp_valid, rsp_err, rsp_rdata, psel);
    else pass_cnt++;
    prdata = '0;
  endtask

  task automatic test_contention();
    int seen;
    int cyc[4];
    logic [1:0] who[4];
    seen = 0;
    req_addr = {32'h200, 32'h100}; req_write = 2'b00; pready = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 20 && seen < 4; c++) begin
      tick();
      total++;
      if (req_ready === 2'b11 || rsp_valid === 2'b11)
        $display("FAIL cont_onehot: got rr=%b rv=%b want at most one bit each", req_ready, rsp_valid);
      else pass_cnt++;
      if (req_ready !== 2'b00) begin
        cyc[seen] = c;
        who[seen] = req_ready;
        total++;
        if (paddr !== (req_ready[1] ? 32'h200 : 32'h100))
          $display("FAIL cont_addr_%0d: got %h want %h", seen, paddr,
                   req_ready[1] ? 32'h200 : 32'h100);
        else pass_cnt++;
        seen++;
        if (seen == 4) req_valid = '0;
      end
    end
    total++;
    if (seen != 4) $display("FAIL cont_count: got %0d want 4", seen);
    else pass_cnt++;
    for (int i = 0; i < seen; i++) begin
      total++;
      if (who[i] !== ((i % 2) ? 2'b10 : 2'b01))
        $display("FAIL cont_order_%0d: got %b want %b", i, who[i], (i % 2) ? 2'b10 : 2'b01);
      else pass_cnt++;
      if (i > 0) begin
        total++;
        if (cyc[i] - cyc[i-1] != 3)
          $display("FAIL cont_spacing_%0d: got %0d want 3", i, cyc[i] - cyc[i-1]);
        else pass_cnt++;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_slave_error();
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h20;
    pready = 1'b1; pslverr = 1'b1; prdata = 8'h77;
    tick();
    req_valid = '0;
    tick();
    tick();
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b1, 8'h77})
      $display("FAIL err_rsp: got v=%b e=%b d=%h want v=01 e=1 d=77", rsp_valid, rsp_err, rsp_rdata);
    else pass_cnt++;
    pslverr = 1'b0; prdata = '0;
  endtask

  task automatic test_timeout();
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h30; req_wdata[15:8] = 8'h5A;
    pready = 1'b0; prdata = 8'hFF;
    tick();
    total++;
    if (req_ready !== 2'b10) $display("FAIL to_grant: got %b want 10", req_ready);
    else pass_cnt++;
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({psel, penable, rsp_valid} !== 4'b1100)
        $display("FAIL to_access_%0d: got %b want 1100", i, {psel, penable, rsp_valid});
      else pass_cnt++;
    end
    tick();
    total++;
    if ({psel, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 2'b10, 1'b1, 8'h00})
      $display("FAIL to_rsp: got sel=%b v=%b e=%b d=%h want sel=0 v=10 e=1 d=00",
               psel, rsp_valid, rsp_err, rsp_rdata);
    else pass_cnt++;
    req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h44; req_wdata[7:0] = 8'hC3;
    pready = 1'b1; prdata = '0;
    tick();
    total++;
    if (req_ready !== 2'b01) $display("FAIL to_next_grant: got %b want 01", req_ready);
    else pass_cnt++;
    req_valid = '0;
    tick();
    tick();
    total++;
    if ({rsp_valid, rsp_err} !== 3'b010)
      $display("FAIL to_next_rsp: got v=%b e=%b want v=01 e=0", rsp_valid, rsp_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h8; pready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    total++;
    if ({psel, penable} !== 2'b11) $display("FAIL rm_in_access: got %b want 11", {psel, penable});
    else pass_cnt++;
    #2 prst = 1'b0;
    #1;
    total++;
    if ({psel, penable} !== 2'b00) $display("FAIL rm_async_drop: got %b want 00", {psel, penable});
    else pass_cnt++;
    pready = 1'b1;
    tick();
    prst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({rsp_valid, psel} !== 3'b000)
        $display("FAIL rm_no_rsp_%0d: got %b want 000", i, {rsp_valid, psel});
      else pass_cnt++;
    end
    req_valid = 2'b11; req_write = 2'b00;
    tick();
    total++;
    if (req_ready !== 2'b01) $display("FAIL rm_first_grant: got %b want 01", req_ready);
    else pass_cnt++;
    req_valid = '0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_slave_error();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
